// File: rtl/dl_arb_pkg.sv
// dl_arb_pkg: shared types and default parameters for the download/RAM arbiter
package dl_arb_pkg;
    typedef logic [15:0] ram_addr_t;
    typedef enum logic [2:0] {IDLE, DL_WR, CPU_WR, CPU_RD, RD_WAIT} dl_arb_state_t;
    localparam logic [7:0] DL_INDEX_DEF   = 8'd1;
    localparam int         HDR_SKIP_DEF   = 16;
    localparam ram_addr_t  LOAD_BASE_DEF  = 16'h0300;
    localparam int         STARVE_MAX_DEF = 8;
endpackage

// File: rtl/dl_byte_buf.sv
// dl_byte_buf: one-entry relocating buffer for download bytes, with sticky overrun flag
module dl_byte_buf
    import dl_arb_pkg::*;
#(
    parameter logic [7:0] DL_INDEX  = DL_INDEX_DEF,
    parameter int         HDR_SKIP  = HDR_SKIP_DEF,
    parameter ram_addr_t  LOAD_BASE = LOAD_BASE_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        drain,
    input  logic        err_clr,
    output logic        buf_valid,
    output ram_addr_t   buf_addr,
    output logic [7:0]  buf_data,
    output logic        dl_err
);
    logic      accept, load;
    logic      buf_valid_q, buf_valid_d, dl_err_q, dl_err_d;
    ram_addr_t buf_addr_q, buf_addr_d;
    logic [7:0] buf_data_q, buf_data_d;

    // Accept matching writes; header bytes are swallowed, payload bytes are relocated into the buffer
    always_comb begin
        accept      = ioctl_download & ioctl_wr & (ioctl_index == DL_INDEX);
        load        = accept & ~buf_valid_q & (ioctl_addr >= 25'(HDR_SKIP));
        buf_valid_d = load ? 1'b1 : drain ? 1'b0 : buf_valid_q;
        buf_addr_d  = load ? ioctl_addr[15:0] - 16'(HDR_SKIP) + LOAD_BASE : buf_addr_q;
        buf_data_d  = load ? ioctl_data : buf_data_q;
        dl_err_d    = (dl_err_q & ~err_clr) | (accept & buf_valid_q);
    end

    // Buffer and error state
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            dl_err_q    <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            dl_err_q    <= dl_err_d;
        end
    end

    assign buf_valid = buf_valid_q;
    assign buf_addr  = buf_addr_q;
    assign buf_data  = buf_data_q;
    assign dl_err    = dl_err_q;
endmodule

// File: rtl/dl_ram_arbiter.sv
// dl_ram_arbiter: shares the main RAM port between the CPU and the ioctl download path.
// Define DL_CHECKSUM_EN to build the mod-256 checksum of downloaded bytes on dl_sum.
module dl_ram_arbiter
    import dl_arb_pkg::*;
#(
    parameter logic [7:0] DL_INDEX   = DL_INDEX_DEF,
    parameter int         HDR_SKIP   = HDR_SKIP_DEF,
    parameter ram_addr_t  LOAD_BASE  = LOAD_BASE_DEF,
    parameter int         STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        dl_active,
    output logic        dl_done,
    output logic        dl_err,
    output logic [7:0]  dl_sum
);
    localparam int            SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    dl_arb_state_t state_q, state_d;
    ram_addr_t     ram_addr_q, ram_addr_d, buf_addr;
    logic [7:0]    ram_din_q, ram_din_d, cpu_dout_q, cpu_dout_d, buf_data;
    logic          ram_we_q, ram_we_d, cpu_ack_q, cpu_ack_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          dl_on_q, dl_on_d, pend_q, pend_d, dl_done_q, dl_done_d;
    logic          buf_valid, match, dl_start, dl_fall, req, drained, ending;

    dl_byte_buf #(
        .DL_INDEX (DL_INDEX),
        .HDR_SKIP (HDR_SKIP),
        .LOAD_BASE(LOAD_BASE)
    ) u_buf (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_data    (ioctl_data),
        .drain         (state_q == DL_WR),
        .err_clr       (dl_start),
        .buf_valid     (buf_valid),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .dl_err        (dl_err)
    );

    // Arbitration, registered RAM port, CPU completion and download-end tracking
    always_comb begin
        match    = ioctl_download & (ioctl_index == DL_INDEX);
        dl_start = match & ~dl_on_q;
        dl_fall  = dl_on_q & ~match;
        // the CPU still holds cpu_req during its ack cycle; masking it stops a finished read replaying
        req      = cpu_req & ~cpu_ack_q;
        drained  = ~buf_valid | (state_q == DL_WR);
        ending   = dl_fall | pend_q;
        case (state_q)
            IDLE:    state_d = (buf_valid & (~req | (starve_q == SMAX))) ? DL_WR :
                               (req & cpu_we) ? CPU_WR : req ? CPU_RD : IDLE;
            CPU_RD:  state_d = RD_WAIT;
            default: state_d = IDLE;
        endcase
        ram_we_d   = (state_d == DL_WR) | (state_d == CPU_WR);
        ram_addr_d = (state_d == DL_WR) ? buf_addr :
                     (state_d == CPU_WR || state_d == CPU_RD) ? cpu_addr : ram_addr_q;
        ram_din_d  = (state_d == DL_WR) ? buf_data : (state_d == CPU_WR) ? cpu_din : ram_din_q;
        cpu_ack_d  = (state_d == CPU_WR) | (state_q == RD_WAIT);
        cpu_dout_d = (state_q == RD_WAIT) ? ram_dout : cpu_dout_q;
        starve_d   = (state_q == DL_WR) ? '0 :
                     (buf_valid && state_d != DL_WR && starve_q != SMAX) ? starve_q + SW'(1) : starve_q;
        dl_on_d    = match;
        pend_d     = ending & ~drained & ~dl_start;
        dl_done_d  = ending & drained;
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            starve_q   <= '0;
            dl_on_q    <= 1'b0;
            pend_q     <= 1'b0;
            dl_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_dout_q <= cpu_dout_d;
            starve_q   <= starve_d;
            dl_on_q    <= dl_on_d;
            pend_q     <= pend_d;
            dl_done_q  <= dl_done_d;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running mod-256 sum of bytes committed to RAM by the download path
    always_comb sum_d = dl_start ? 8'h00 : (state_q == DL_WR) ? sum_q + ram_din_q : sum_q;

    // Checksum register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign dl_sum = sum_q;
`else
    assign dl_sum = 8'h00;
`endif

    assign ioctl_wait = buf_valid;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_we     = ram_we_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_dout   = cpu_dout_q;
    assign dl_active  = dl_on_q | buf_valid;
    assign dl_done    = dl_done_q;
endmodule

// File: tb/tb_dl_ram_arbiter.sv
// tb_dl_ram_arbiter: scoreboard bench for dl_ram_arbiter with a behavioural RAM image model
module tb_dl_ram_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0, ioctl_data = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic        ioctl_wait;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'd0;
    logic [7:0]  cpu_din = 8'd0, cpu_dout;
    logic        cpu_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din, ram_dout = 8'd0;
    logic        ram_we, dl_active, dl_done, dl_err;
    logic [7:0]  dl_sum;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          we;
        int          t0;
        int          lo;
        int          hi;
    } exp_t;

    exp_t        dlq[$], cpuq[$];
    int          done_q[$];
    logic [15:0] touched[$];
    bit [7:0]    mem[65536], ref_mem[65536];
    logic [7:0]  exp_sum = 8'd0;
    int          vectors = 0, miscompares = 0, cyc = 0;

    dl_ram_arbiter dut (
        .clk_sys(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .dl_active(dl_active), .dl_done(dl_done), .dl_err(dl_err), .dl_sum(dl_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int v, input int lo, input int hi);
        vectors++;
        if (v < lo || v > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
        end
    endtask

    function automatic logic [63:0] outs();
        return {18'b0, ioctl_wait, cpu_dout, cpu_ack, ram_addr, ram_din, ram_we,
                dl_active, dl_done, dl_err, dl_sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: pops expectations whenever the DUT completes a RAM write or CPU access
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cpu_ack) begin
                if (cpuq.size() == 0) check("cpu_ack_unexpected", cpu_ack, 0);
                else begin
                    e = cpuq.pop_front();
                    chk_range("cpu_latency", cyc - e.t0, e.lo, e.hi);
                    if (e.we) check("cpu_wr_port", {ram_we, ram_addr, ram_din}, {1'b1, e.addr, e.data});
                    else      check("cpu_rd_data", cpu_dout, e.data);
                end
            end
            if (ram_we && !cpu_ack) begin
                if (dlq.size() == 0) check("dl_wr_unexpected", ram_we, 0);
                else begin
                    e = dlq.pop_front();
                    check("dl_wr", {ram_addr, ram_din}, {e.addr, e.data});
                    chk_range("dl_latency", cyc - e.t0, e.lo, e.hi);
                end
            end
            if (dl_done) done_q.push_back(cyc);
        end
    end

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input bit timed);
        int n = 0;
        bit kept, matching;
        logic [15:0] ea;
        while (ioctl_wait && n < 50) begin tick(); n++; end
        check("wait_released", ioctl_wait, 0);
        matching = ioctl_download && ioctl_index == 8'd1;
        kept = matching && a >= 25'd16;
        ea = 16'(a - 25'd16) + 16'h0300;
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        if (kept) begin
            dlq.push_back('{addr: ea, data: d, we: 1'b1, t0: cyc, lo: 2, hi: timed ? 2 : 14});
            ref_mem[ea] = d;
            touched.push_back(ea);
            exp_sum = exp_sum + d;
        end
        tick();
        ioctl_wr = 1'b0;
        if (timed) begin
            check("wait_rise", ioctl_wait, kept);
            check("dl_active", dl_active, matching);
            tick(); tick();
            check("wait_fall", ioctl_wait, 0);
        end
    endtask

    task automatic download(input int n, input logic [7:0] idx, input bit timed, input bit rnd);
        int f, w = 0;
        ioctl_index = idx; ioctl_download = 1'b1;
        if (idx == 8'd1) exp_sum = 8'd0;
        tick();
        if (idx == 8'd1) check("dl_err_clear_at_start", dl_err, 0);
        for (int i = 0; i < n; i++) begin
            dl_byte(25'(i), rnd ? 8'($urandom) : 8'(i + 1), timed);
            if (rnd) repeat ($urandom_range(0, 3)) tick();
        end
        ioctl_download = 1'b0;
        f = cyc;
        while (dl_active && w < 40) begin tick(); w++; end
        check("drained", dl_active, 0);
        repeat (2) tick();
        if (idx == 8'd1) begin
            check("done_count", done_q.size(), 1);
            if (timed && done_q.size() > 0) check("done_cycle", done_q[0], f + 1);
        end else check("done_count_nomatch", done_q.size(), 0);
        done_q.delete();
    endtask

    task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d, input int lo, input int hi);
        int n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        cpuq.push_back('{addr: a, data: we ? d : ref_mem[a], we: we, t0: cyc, lo: lo, hi: hi});
        if (we) begin ref_mem[a] = d; touched.push_back(a); end
        do begin tick(); n++; end while (!cpu_ack && n < 50);
        check("cpu_ack_seen", cpu_ack, 1);
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic sum_check();
`ifdef DL_CHECKSUM_EN
        check("dl_sum", dl_sum, exp_sum);
`else
        check("dl_sum_off", dl_sum, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        tick();
        check("idle_outputs", outs(), 0);

        download(20, 8'd1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) check("ram_0300", mem[16'h0300 + 16'(i)], 64'(8'h11 + i));
        sum_check();

        download(20, 8'd2, 1'b1, 1'b0);
        check("no_err_nomatch", dl_err, 0);

        cpu_op(1'b1, 16'h1234, 8'hA5, 1, 1);
        cpu_op(1'b0, 16'h1234, 8'h00, 3, 3);

        ioctl_index = 8'd1; ioctl_download = 1'b1; exp_sum = 8'd0;
        tick();
        dl_byte(25'd16, 8'h77, 1'b0);
        check("wait_during_buf", ioctl_wait, 1);
        ioctl_addr = 25'd17; ioctl_data = 8'h88; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        check("dl_err_set", dl_err, 1);
        ioctl_download = 1'b0;
        repeat (4) tick();
        check("done_after_overrun", done_q.size(), 1);
        done_q.delete();
        check("dl_err_sticky", dl_err, 1);
        check("ram_overrun_keep", mem[16'h0300], 8'h77);
        check("ram_overrun_drop", mem[16'h0301], 8'h12);
        sum_check();

        fork
            download(40, 8'd1, 1'b0, 1'b1);
            for (int k = 0; k < 60; k++) begin
                bit w;
                w = 1'($urandom_range(0, 1));
                cpu_op(w, 16'h8000 | 16'($urandom_range(0, 15)), 8'($urandom), w ? 1 : 3, w ? 3 : 5);
                repeat ($urandom_range(0, 2)) tick();
            end
        join
        sum_check();

        ioctl_index = 8'd1; ioctl_download = 1'b1;
        tick();
        ioctl_addr = 25'd16; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        check("pre_reset_dl_wr", ram_we, 1);
        reset = 1'b1;
        #1;
        check("reset_async_outputs", outs(), 0);
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_wait", ioctl_wait, 0);
        check("post_reset_active", dl_active, 0);
        download(18, 8'd1, 1'b1, 1'b0);
        check("ram_after_reset_0", mem[16'h0300], 8'h11);
        check("ram_after_reset_1", mem[16'h0301], 8'h12);
        sum_check();

        check("dlq_empty", dlq.size(), 0);
        check("cpuq_empty", cpuq.size(), 0);
        foreach (touched[i]) check("ram_image", mem[touched[i]], ref_mem[touched[i]]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dl_ram_arbiter.md
# dl_ram_arbiter

Shares the core's single main-RAM port between the Z80 CPU and the HPS ioctl download path, so that TAP images can be loaded while the CPU runs. Download bytes for the configured ioctl index are header-stripped, relocated to a load address and held in a one-byte buffer. `ioctl_wait` is raised while that buffer is occupied. A fixed-priority arbiter with a starvation guard interleaves buffered writes with CPU reads and writes. The block sits between `hps_io` and the RAM instance inside the PolyPlay core, in the `clk_sys` domain.

## Interface
Parameters:
- `DL_INDEX`, default 8'd1: the `ioctl_index` value accepted as a load. All other indices are ignored.
- `HDR_SKIP`, default 16: count of leading stream bytes (`ioctl_addr < HDR_SKIP`) that are accepted and discarded.
- `LOAD_BASE`, default 16'h0300: RAM address that receives stream byte `HDR_SKIP`.
- `STARVE_MAX`, default 8: cycles a buffered byte may wait behind CPU requests before it is granted.

Ports:
- `clk_sys` in 1: the single clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1, `ioctl_index` in 8, `ioctl_wr` in 1, `ioctl_addr` in 25, `ioctl_data` in 8: the `hps_io` download stream.
- `ioctl_wait` out 1: stall request to `hps_io`.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in 16, `cpu_din` in 8: the CPU access request.
- `cpu_dout` out 8: read data returned to the CPU.
- `cpu_ack` out 1: one-cycle completion pulse.
- `ram_addr` out 16, `ram_din` out 8, `ram_we` out 1: the RAM port, registered. The RAM is synchronous with one-cycle read latency.
- `ram_dout` in 8: RAM read data.
- `dl_active` out 1: a matching download is in progress, or the buffer is not yet drained.
- `dl_done` out 1: one-cycle pulse when a matching download has finished and fully drained.
- `dl_err` out 1: sticky overrun flag.
- `dl_sum` out 8: download checksum. See Configuration.

## Operation
- Reset value of every output is 0. On reset the state returns to IDLE, the buffer is emptied, and `starve_cnt` is cleared.
- Accept condition: `ioctl_download & ioctl_wr & (ioctl_index == DL_INDEX)`.
  - If `ioctl_addr < HDR_SKIP`, the byte is dropped and no wait is raised.
  - Otherwise the byte is latched into `buf_data`, `buf_valid` is set, and `buf_addr` = `LOAD_BASE + (ioctl_addr - HDR_SKIP)`, truncated to 16 bits (addresses wrap past FFFF).
- Overrun: an accepted write that arrives while `buf_valid` is set is dropped and sets `dl_err`. `dl_err` and `dl_sum` clear on the rising edge of a matching `ioctl_download`.
- `ioctl_wait` is a registered copy of `buf_valid`.
- States:
  - IDLE:
    - If `buf_valid & (!cpu_req | starve_cnt == STARVE_MAX)`, go to DL_WR.
    - Else if `cpu_req & cpu_we`, go to CPU_WR.
    - Else if `cpu_req`, go to CPU_RD.
    - Else stay in IDLE.
  - DL_WR: `ram_addr`=`buf_addr`, `ram_din`=`buf_data`, `ram_we`=1 for one cycle. Clear `buf_valid` and `starve_cnt`, then go to IDLE.
  - CPU_WR: `ram_addr`=`cpu_addr`, `ram_din`=`cpu_din`, `ram_we`=1, `cpu_ack`=1 in the same cycle. Go to IDLE.
  - CPU_RD: present `ram_addr`, then go to RD_WAIT.
  - RD_WAIT: capture `ram_dout` into `cpu_dout` and pulse `cpu_ack` in the next cycle. Go to IDLE.
- `starve_cnt` increments, saturating at `STARVE_MAX`, in every cycle where `buf_valid` is set and DL_WR is not entered.
- CPU protocol: the CPU holds `cpu_req` and its operands stable until `cpu_ack`, and deasserts `cpu_req` in the cycle after `cpu_ack`.
- Download end: if `ioctl_download` falls while `buf_valid` is set, the buffer still drains. `dl_done` pulses in the cycle after the final DL_WR. With an empty buffer, `dl_done` pulses one cycle after the falling edge.

## Timing
- Download write with no CPU contention:
  - `ioctl_wr` is seen at cycle t.
  - Cycle t+1: `buf_valid`=1, `ioctl_wait`=1.
  - Cycle t+2: DL_WR, so `ram_we`=1.
  - Cycle t+3: `ioctl_wait`=0.
- CPU write: grant at t, `ram_we` and `cpu_ack` at t+1.
- CPU read: grant at t, address presented at t+1, `cpu_dout` and `cpu_ack` valid at t+3.
- Worst-case wait for a buffered byte under continuous CPU requests: `STARVE_MAX` plus one CPU transaction (4 cycles).
- Simultaneous `cpu_req` and an already-valid buffer with `starve_cnt < STARVE_MAX`: the CPU wins.

## Configuration
- `DL_CHECKSUM_EN` defined: `dl_sum` is the mod-256 sum of every byte written in DL_WR. It updates in the DL_WR cycle and clears at the rising edge of a matching download.
- Not defined: `dl_sum` is tied to 0 and no adder is built.

## Structure
- Package `dl_arb_pkg`:
  - state enum `dl_arb_state_t` (IDLE, DL_WR, CPU_WR, CPU_RD, RD_WAIT);
  - default parameter constants;
  - `ram_addr_t` typedef (16 bits).
- Sub-module `dl_byte_buf` holds the one-entry byte/address buffer. It contains the accept/relocate/overrun logic and drives `buf_valid`, `buf_addr`, `buf_data` and `dl_err`.

## Test plan
- Matching download of 20 bytes 0x01..0x14 with `HDR_SKIP`=16, no CPU traffic -> RAM[0x0300..0x0303] = 0x11..0x14; `dl_done` pulses once; `dl_sum` = 0x4A when `DL_CHECKSUM_EN` is defined.
- `ioctl_index`=2 download -> no `ram_we`, `ioctl_wait` stays 0, `dl_active` stays 0.
- Continuous `cpu_req` reads while one byte is buffered -> DL_WR is granted within 8 cycles plus one read; every CPU read returns correct data 3 cycles after grant.
- CPU write of 0xA5 to 0x1234, then a read of the same address -> `cpu_ack` at t+1 for the write; the read returns 0xA5 at t+3.
- `ioctl_wr` while `ioctl_wait`=1 -> byte dropped, `dl_err`=1; `dl_err` clears at the next download start.
- `reset` asserted mid-DL_WR -> all outputs 0 immediately, buffer empty, next download lands correctly.
